// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the ALU itself.
// Optional feature macro used by the files of this slice: ALU_CTRL_ILLEGAL_EN
package alu_pkg;

  // ALU operation codes (1110 and 1111 are reserved and never produced)
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_ADDU = 4'b1100;
  localparam logic [3:0] ALU_SUBU = 4'b1101;

  // Instruction class carried in aluOp[1:0]
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  // Decoded control word that gets registered at the ID/EX boundary
  typedef struct packed {
    logic [3:0] op;
    logic       shiftVar;
  } dec_t;

  // I-type opcode[3:0] to operation; the lower half of the space has no
  // ALU meaning here and falls back to ADD
  function automatic logic [3:0] iTypeDecode(input logic [3:0] opc);
    logic [3:0] res;
    res = ALU_ADD;
    case (opc)
      4'b1000: res = ALU_ADD;
      4'b1001: res = ALU_ADDU;
      4'b1010: res = ALU_SLT;
      4'b1011: res = ALU_SLTU;
      4'b1100: res = ALU_AND;
      4'b1101: res = ALU_OR;
      4'b1110: res = ALU_XOR;
      4'b1111: res = ALU_LUI;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Bundle of the decoder inputs and registered outputs.
// Optional feature macro: ALU_CTRL_ILLEGAL_EN adds the illegal flag.
interface alu_ctrl_if;
  import alu_pkg::*;

  logic [5:0] ff;
  logic [5:0] aluOp;
  logic [3:0] operation;
  logic       shift_var;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       illegal;
`endif

`ifdef ALU_CTRL_ILLEGAL_EN
  modport master (output ff, output aluOp,
                  input operation, input shift_var, input illegal);
  modport slave  (input ff, input aluOp,
                  output operation, output shift_var, output illegal);
`else
  modport master (output ff, output aluOp,
                  input operation, input shift_var);
  modport slave  (input ff, input aluOp,
                  output operation, output shift_var);
`endif

endinterface

// File: rtl/alu_funct_dec.sv
// Combinational R-type funct decoder: funct field to ALU operation and
// shift-source select. Optional macro ALU_CTRL_ILLEGAL_EN adds illegal_o.
module alu_funct_dec
  import alu_pkg::*;
(
  input  logic [5:0] ff_i,
  output logic [3:0] operation_o,
`ifdef ALU_CTRL_ILLEGAL_EN
  output logic       illegal_o,
`endif
  output logic       shift_var_o
);

  logic legal;

  // Map every listed funct; anything unlisted is treated as ADD and flagged
  always_comb begin
    operation_o = ALU_ADD;
    shift_var_o = 1'b0;
    legal       = 1'b1;
    case (ff_i)
      FN_SLL:  operation_o = ALU_SLL;
      FN_SRL:  operation_o = ALU_SRL;
      FN_SRA:  operation_o = ALU_SRA;
      FN_SLLV: begin operation_o = ALU_SLL; shift_var_o = 1'b1; end
      FN_SRLV: begin operation_o = ALU_SRL; shift_var_o = 1'b1; end
      FN_SRAV: begin operation_o = ALU_SRA; shift_var_o = 1'b1; end
      FN_JR:   operation_o = ALU_ADD;
      FN_ADD:  operation_o = ALU_ADD;
      FN_ADDU: operation_o = ALU_ADDU;
      FN_SUB:  operation_o = ALU_SUB;
      FN_SUBU: operation_o = ALU_SUBU;
      FN_AND:  operation_o = ALU_AND;
      FN_OR:   operation_o = ALU_OR;
      FN_XOR:  operation_o = ALU_XOR;
      FN_NOR:  operation_o = ALU_NOR;
      FN_SLT:  operation_o = ALU_SLT;
      FN_SLTU: operation_o = ALU_SLTU;
      default: begin operation_o = ALU_ADD; legal = 1'b0; end
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  assign illegal_o = ~legal;
`else
  logic unusedLegal;
  assign unusedLegal = legal;
`endif

endmodule

// File: rtl/alu_ctrl.sv
// ALU control decoder for the execute stage: class/funct/opcode decode,
// registered once so it lines up with the ID/EX pipeline boundary.
// Optional macro ALU_CTRL_ILLEGAL_EN adds a registered illegal flag.
module alu_ctrl
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  alu_ctrl_if.slave bus
);

  dec_t       ctrl_d, ctrl_q;
  logic [3:0] fnOp;
  logic       fnShift;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       fnIllegal;
  logic       illegal_d, illegal_q;
`endif

  alu_funct_dec u_funct_dec (
    .ff_i        (bus.ff),
    .operation_o (fnOp),
`ifdef ALU_CTRL_ILLEGAL_EN
    .illegal_o   (fnIllegal),
`endif
    .shift_var_o (fnShift)
  );

  // Pick the decode path by class; unknown class patterns land on ADD
  always_comb begin
    ctrl_d.op       = ALU_ADD;
    ctrl_d.shiftVar = 1'b0;
    case (bus.aluOp[1:0])
      ALUOP_MEM: ctrl_d.op = ALU_ADD;
      ALUOP_BR:  ctrl_d.op = ALU_SUB;
      ALUOP_R: begin
        ctrl_d.op       = fnOp;
        ctrl_d.shiftVar = fnShift;
      end
      ALUOP_I:   ctrl_d.op = iTypeDecode(bus.aluOp[5:2]);
      default:   ctrl_d.op = ALU_ADD;
    endcase
  end

`ifdef ALU_CTRL_ILLEGAL_EN
  // Flag unlisted functs and the unused lower half of the I-type opcodes
  always_comb begin
    illegal_d = 1'b0;
    case (bus.aluOp[1:0])
      ALUOP_R: illegal_d = fnIllegal;
      ALUOP_I: illegal_d = ~bus.aluOp[5];
      default: illegal_d = 1'b0;
    endcase
  end

  // Illegal flag register, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign bus.illegal = illegal_q;
`endif

  // Output register; reset wins over the decode and parks the ALU on ADD
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q.op       <= ALU_ADD;
      ctrl_q.shiftVar <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.operation = ctrl_q.op;
  assign bus.shift_var = ctrl_q.shiftVar;

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: directed steps followed by random
// traffic, compared cycle by cycle against a table-driven reference.
// Honours ALU_CTRL_ILLEGAL_EN when the design is built with it.
module tb_alu_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  logic [3:0] rOp    [64];
  logic       rShift [64];
  logic       rIll   [64];
  logic [3:0] iOp    [16];

  logic [3:0] expOp;
  logic       expShift;
  logic       expIll;

  always #5 clk = ~clk;

  alu_ctrl_if bus ();

  alu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Fill one legal R-type row of the reference table
  task automatic setR(input int idx, input logic [3:0] op, input logic s);
    rOp[idx]    = op;
    rShift[idx] = s;
    rIll[idx]   = 1'b0;
  endtask

  // Reference decode straight from the instruction-class rules
  task automatic model(input logic r, input logic [5:0] a, input logic [5:0] f);
    expOp    = 4'b0010;
    expShift = 1'b0;
    expIll   = 1'b0;
    if (!r) begin
      if (a[1:0] == 2'b01) begin
        expOp = 4'b0110;
      end else if (a[1:0] == 2'b10) begin
        expOp    = rOp[f];
        expShift = rShift[f];
        expIll   = rIll[f];
      end else if (a[1:0] == 2'b11) begin
        expOp  = iOp[a[5:2]];
        expIll = (a[5:2] < 4'd8);
      end
    end
  endtask

  // Compare the registered outputs with the reference
  task automatic checkOutput(input string tag);
    total++;
    assert (bus.operation === expOp) else begin
      bad++;
      $error("[TB] FAIL %s operation: got %b want %b", tag, bus.operation, expOp);
    end
    total++;
    assert (bus.shift_var === expShift) else begin
      bad++;
      $error("[TB] FAIL %s shift_var: got %b want %b", tag, bus.shift_var, expShift);
    end
`ifdef ALU_CTRL_ILLEGAL_EN
    total++;
    assert (bus.illegal === expIll) else begin
      bad++;
      $error("[TB] FAIL %s illegal: got %b want %b", tag, bus.illegal, expIll);
    end
`endif
  endtask

  // Drive one cycle of inputs, then check the outputs just after the edge
  task automatic applyStimulus(input logic r, input logic [5:0] a,
                               input logic [5:0] f, input string tag);
    @(negedge clk);
    reset     = r;
    bus.aluOp = a;
    bus.ff    = f;
    model(r, a, f);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rOp[i] = 4'b0010; rShift[i] = 1'b0; rIll[i] = 1'b1;
    end
    setR(0,  4'b0101, 1'b0); setR(2,  4'b1001, 1'b0); setR(3,  4'b1010, 1'b0);
    setR(4,  4'b0101, 1'b1); setR(6,  4'b1001, 1'b1); setR(7,  4'b1010, 1'b1);
    setR(8,  4'b0010, 1'b0);
    setR(32, 4'b0010, 1'b0); setR(33, 4'b1100, 1'b0);
    setR(34, 4'b0110, 1'b0); setR(35, 4'b1101, 1'b0);
    setR(36, 4'b0000, 1'b0); setR(37, 4'b0001, 1'b0);
    setR(38, 4'b0011, 1'b0); setR(39, 4'b0100, 1'b0);
    setR(42, 4'b0111, 1'b0); setR(43, 4'b1000, 1'b0);
    for (int i = 0; i < 8; i++) iOp[i] = 4'b0010;
    iOp[8]  = 4'b0010; iOp[9]  = 4'b1100; iOp[10] = 4'b0111; iOp[11] = 4'b1000;
    iOp[12] = 4'b0000; iOp[13] = 4'b0001; iOp[14] = 4'b0011; iOp[15] = 4'b1011;

    reset     = 1'b1;
    bus.aluOp = 6'b000010;
    bus.ff    = 6'b100010;

    $display("[TB] reset and release");
    applyStimulus(1'b1, 6'b000010, 6'b100010, "reset0");
    applyStimulus(1'b1, 6'b000010, 6'b100010, "reset1");
    applyStimulus(1'b0, 6'b000010, 6'b100010, "afterReset");

    $display("[TB] class decode");
    applyStimulus(1'b0, 6'b000000, 6'b000000, "mem");
    applyStimulus(1'b0, 6'b000001, 6'b000000, "branch");
    applyStimulus(1'b0, 6'b000011, 6'b000000, "iLowAdd");

    $display("[TB] R-type sweep");
    applyStimulus(1'b0, 6'b000010, 6'b100010, "rSub");
    applyStimulus(1'b0, 6'b000010, 6'b000100, "rSllv");
    applyStimulus(1'b0, 6'b000010, 6'b000000, "rSll");
    applyStimulus(1'b0, 6'b000010, 6'b101010, "rSlt");
    applyStimulus(1'b0, 6'b000010, 6'b000101, "rUndef5");
    applyStimulus(1'b0, 6'b000010, 6'b001010, "rUndef10");
    applyStimulus(1'b0, 6'b000010, 6'b010000, "rUndef16");
    applyStimulus(1'b0, 6'b000010, 6'b000111, "rSrav");
    applyStimulus(1'b0, 6'b000010, 6'b100011, "rSubu");

    $display("[TB] I-type sweep");
    applyStimulus(1'b0, 6'b100011, 6'b001010, "iAdd");
    applyStimulus(1'b0, 6'b100111, 6'b001010, "iAddu");
    applyStimulus(1'b0, 6'b101011, 6'b001010, "iSlt");
    applyStimulus(1'b0, 6'b101111, 6'b001010, "iSltu");
    applyStimulus(1'b0, 6'b110011, 6'b001010, "iAnd");
    applyStimulus(1'b0, 6'b110111, 6'b001010, "iOr");
    applyStimulus(1'b0, 6'b111011, 6'b001010, "iXor");
    applyStimulus(1'b0, 6'b111111, 6'b001010, "iLui");

    $display("[TB] mid-sequence reset");
    applyStimulus(1'b0, 6'b000001, 6'b000000, "preReset");
    applyStimulus(1'b1, 6'b000001, 6'b000110, "midReset");
    applyStimulus(1'b0, 6'b000010, 6'b000110, "postReset");

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      logic       r;
      logic [5:0] a;
      logic [5:0] f;
      r = ($urandom_range(0, 19) == 0);
      a = 6'($urandom);
      f = 6'($urandom);
      if ($urandom_range(0, 1) == 1) f = {1'b1, 5'($urandom_range(0, 11))};
      applyStimulus(r, a, f, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
